alu_mac_array: RTL

Parametrised, multi-lane successor to the single-lane floating-point multiply-accumulate ALU. `LANES` independent MAC lanes share one streamed input scaler, and each lane holds its own weight. The block computes `LANES` rows of a matrix-vector dot product over a programmable vector length. It adds a start/length command, valid/ready streaming on input and output, a registered multiply stage, and automatic accumulator clear per vector. It sits between the input FIFO / weight ROM and the activation stage of the neural datapath.

---
 rtl/alu_mac_array_if.sv | 31 +++
 rtl/alu_mac_array.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mac_array_if.sv
// Streaming command/data/result bundle for alu_mac_array.
// The master drives commands and beats; the slave returns the per-lane dot products.
interface alu_mac_array_if #(
   parameter int BIT_WIDTH  = 32,
   parameter int EXTRA_BITS = 2,
   parameter int LANES      = 4,
   parameter int LEN_W      = 8
);
   localparam int W = BIT_WIDTH + EXTRA_BITS;

   logic                 START;
   logic [LEN_W-1:0]     VEC_LEN;
   logic                 IN_VALID;
   logic                 IN_READY;
   logic [W-1:0]         INPUT_SCALER;
   logic [LANES*W-1:0]   WEIGHT_VEC;
   logic                 OUT_VALID;
   logic                 OUT_READY;
   logic [LANES*W-1:0]   ACC_RESULT;
   logic                 BUSY;

   modport master (
      output START, VEC_LEN, IN_VALID, INPUT_SCALER, WEIGHT_VEC, OUT_READY,
      input  IN_READY, OUT_VALID, ACC_RESULT, BUSY
   );

   modport slave (
      input  START, VEC_LEN, IN_VALID, INPUT_SCALER, WEIGHT_VEC, OUT_READY,
      output IN_READY, OUT_VALID, ACC_RESULT, BUSY
   );
endinterface

// File: rtl/alu_mac_array.sv
// Multi-lane float MAC array: LANES dot products over a streamed vector, with
// flopoco-format {exc, sign, exp, frac} multiply and add primitives per lane.
module FPmul_nonpipe (
   input  logic [33:0] X,
   input  logic [33:0] Y,
   output logic [33:0] R
);
   logic [47:0]       prod;
   logic signed [9:0] exp_n;
   logic [22:0]       frac_n;
   logic              guard, sticky, rnd, sign_r;
   logic [32:0]       packed_r;

   always_comb begin
      sign_r = X[31] ^ Y[31];
      prod   = 48'({1'b1, X[22:0]}) * 48'({1'b1, Y[22:0]});
      exp_n  = $signed({2'b00, X[30:23]}) + $signed({2'b00, Y[30:23]}) - 10'sd127;
      if (prod[47]) begin
         frac_n = prod[46:24];
         guard  = prod[23];
         sticky = |prod[22:0];
         exp_n  = exp_n + 10'sd1;
      end else begin
         frac_n = prod[45:23];
         guard  = prod[22];
         sticky = |prod[21:0];
      end
      rnd      = guard & (sticky | frac_n[0]);
      // Rounding carry ripples straight into the exponent field.
      packed_r = {exp_n, frac_n} + 33'(rnd);
      if (X[33:32] == 2'b11 || Y[33:32] == 2'b11 ||
          (X[33:32] == 2'b10 && Y[33:32] == 2'b00) ||
          (X[33:32] == 2'b00 && Y[33:32] == 2'b10))
         R = {2'b11, 32'h0};
      else if (X[33:32] == 2'b10 || Y[33:32] == 2'b10)
         R = {2'b10, sign_r, 31'h0};
      else if (X[33:32] == 2'b00 || Y[33:32] == 2'b00 || packed_r[32])
         R = {2'b00, sign_r, 31'h0};
      else if (packed_r[31])
         R = {2'b10, sign_r, 31'h0};
      else
         R = {2'b01, sign_r, packed_r[30:0]};
   end
endmodule

module FPAdder_nonpipe (
   input  logic [33:0] X,
   input  logic [33:0] Y,
   output logic [33:0] R
);
   logic              swap, sub, sticky, rnd;
   logic [33:0]       a, b;
   logic [7:0]        diff;
   logic [26:0]       mb;
   logic [27:0]       sum;
   logic signed [9:0] exp_n;
   logic [32:0]       packed_r;

   always_comb begin
      swap   = (X[30:0] < Y[30:0]);
      a      = swap ? Y : X;
      b      = swap ? X : Y;
      diff   = a[30:23] - b[30:23];
      sub    = a[31] ^ b[31];
      sticky = 1'b0;
      mb     = {1'b1, b[22:0], 3'b000};
      if (diff > 8'd26) begin
         mb = 27'd1;
      end else begin
         sticky = |(mb & ((27'd1 << diff) - 27'd1));
         mb     = (mb >> diff) | 27'(sticky);
      end
      sum   = sub ? ({2'b01, a[22:0], 3'b000} - {1'b0, mb})
                  : ({2'b01, a[22:0], 3'b000} + {1'b0, mb});
      exp_n = $signed({2'b00, a[30:23]});
      if (sum[27]) begin
         sum   = {1'b0, sum[27:2], sum[1] | sum[0]};
         exp_n = exp_n + 10'sd1;
      end else begin
         for (int i = 0; i < 26; i++) begin
            if (!sum[26]) begin
               sum   = sum << 1;
               exp_n = exp_n - 10'sd1;
            end
         end
      end
      rnd      = sum[2] & (sum[1] | sum[0] | sum[3]);
      packed_r = {exp_n, sum[25:3]} + 33'(rnd);
      if (X[33:32] == 2'b11 || Y[33:32] == 2'b11 ||
          (X[33:32] == 2'b10 && Y[33:32] == 2'b10 && X[31] != Y[31]))
         R = {2'b11, 32'h0};
      else if (X[33:32] == 2'b10)
         R = {2'b10, X[31], 31'h0};
      else if (Y[33:32] == 2'b10)
         R = {2'b10, Y[31], 31'h0};
      else if (X[33:32] == 2'b00 && Y[33:32] == 2'b00)
         R = {2'b00, X[31] & Y[31], 31'h0};
      else if (X[33:32] == 2'b00)
         R = Y;
      else if (Y[33:32] == 2'b00)
         R = X;
      else if (sum == 28'd0 || packed_r[32])
         R = {2'b00, (sum == 28'd0) ? 1'b0 : a[31], 31'h0};
      else if (packed_r[31])
         R = {2'b10, a[31], 31'h0};
      else
         R = {2'b01, a[31], packed_r[30:0]};
   end
endmodule

module alu_mac_array #(
   parameter int BIT_WIDTH  = 32,
   parameter int EXTRA_BITS = 2,
   parameter int LANES      = 4,
   parameter int LEN_W      = 8
) (
   input logic             CLK,
   input logic             RESET_N,
   alu_mac_array_if.slave  bus
);
   localparam int W = BIT_WIDTH + EXTRA_BITS;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             first_q, first_d;
   logic             s0_valid_q, s0_valid_d, s0_first_q, s0_first_d, s0_last_q, s0_last_d;
   logic             s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
   logic [33:0]      in_q, in_d, in_fp;
   logic [33:0]      w_q [LANES];
   logic [33:0]      w_d [LANES];
   logic [33:0]      w_fp [LANES];
   logic [33:0]      prod_q [LANES];
   logic [33:0]      prod_d [LANES];
   logic [33:0]      prod_w [LANES];
   logic [33:0]      acc_q [LANES];
   logic [33:0]      acc_d [LANES];
   logic [33:0]      addend [LANES];
   logic [33:0]      sum_w [LANES];

   // A port without exception bits is treated as an ordinary normal number.
   assign in_fp = (EXTRA_BITS == 0) ? {2'b01, 32'(bus.INPUT_SCALER)} : 34'(bus.INPUT_SCALER);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign w_fp[i]   = (EXTRA_BITS == 0) ? {2'b01, 32'(bus.WEIGHT_VEC[i*W +: W])}
                                           : 34'(bus.WEIGHT_VEC[i*W +: W]);
      assign addend[i] = s1_first_q ? 34'h0 : acc_q[i];
      FPmul_nonpipe   u_mul (.X(in_q),      .Y(w_q[i]),    .R(prod_w[i]));
      FPAdder_nonpipe u_add (.X(prod_q[i]), .Y(addend[i]), .R(sum_w[i]));
      assign bus.ACC_RESULT[i*W +: W] = W'(acc_q[i]);
   end

   assign bus.IN_READY  = (state_q == RUN);
   assign bus.OUT_VALID = (state_q == HOLD);
   assign bus.BUSY      = (state_q != IDLE);

   // The first/last tags ride with each beat so gaps never corrupt the running sum.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      first_d    = first_q;
      in_d       = in_q;
      s0_valid_d = 1'b0;
      s0_first_d = s0_first_q;
      s0_last_d  = s0_last_q;
      s1_valid_d = s0_valid_q;
      s1_first_d = s0_first_q;
      s1_last_d  = s0_last_q;
      for (int i = 0; i < LANES; i++) begin
         w_d[i]    = w_q[i];
         prod_d[i] = s0_valid_q ? prod_w[i] : prod_q[i];
         acc_d[i]  = s1_valid_q ? sum_w[i] : acc_q[i];
      end
      case (state_q)
         IDLE: begin
            if (bus.START) begin
               if (bus.VEC_LEN != '0) begin
                  cnt_d   = bus.VEC_LEN;
                  first_d = 1'b1;
                  state_d = RUN;
               end else begin
                  for (int i = 0; i < LANES; i++) acc_d[i] = 34'h0;
                  state_d = HOLD;
               end
            end
         end
         RUN: begin
            if (bus.IN_VALID) begin
               s0_valid_d = 1'b1;
               s0_first_d = first_q;
               s0_last_d  = (cnt_q == LEN_W'(1));
               in_d       = in_fp;
               for (int i = 0; i < LANES; i++) w_d[i] = w_fp[i];
               first_d    = 1'b0;
               cnt_d      = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (s1_valid_q && s1_last_q) state_d = HOLD;
         end
         HOLD: begin
            if (bus.OUT_READY) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         first_q    <= 1'b0;
         in_q       <= '0;
         s0_valid_q <= 1'b0;
         s0_first_q <= 1'b0;
         s0_last_q  <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            w_q[i]    <= '0;
            prod_q[i] <= '0;
            acc_q[i]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         in_q       <= in_d;
         s0_valid_q <= s0_valid_d;
         s0_first_q <= s0_first_d;
         s0_last_q  <= s0_last_d;
         s1_valid_q <= s1_valid_d;
         s1_first_q <= s1_first_d;
         s1_last_q  <= s1_last_d;
         for (int i = 0; i < LANES; i++) begin
            w_q[i]    <= w_d[i];
            prod_q[i] <= prod_d[i];
            acc_q[i]  <= acc_d[i];
         end
      end
   end
endmodule
